uart_tx_fifo_cfg: RTL

Parametrised UART transmitter, successor to the fixed 8N2 transmitter. Adds configurable data width, parity, stop-bit count and bit order, a runtime baud divisor, and an input FIFO with valid/ready handshake. It sits between protocol/bridge logic and the FPGA UART pads, so producers can post bursts without polling busy.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_tx_fifo_cfg.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM state type and frame-length helper
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Bit periods in one frame: start + data + optional parity + stop bits.
    function automatic int frame_bits(input int data_bits, input int parity_mode, input int stop_bits);
        return 1 + data_bits + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with wrapping pointers and occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic                             push,
    input  logic [WIDTH-1:0]                 wdata,
    input  logic                             pop,
    output logic [WIDTH-1:0]                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             full,
    output logic                             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count   = wptr - rptr;
    assign rdata   = mem[rptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer update; clear empties the FIFO without touching storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// rtl/uart_tx_fifo_cfg.sv - FIFO-fed configurable UART transmitter (optional UART_TX_BREAK_EN)
module uart_tx_fifo_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int LSB_FIRST   = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
`ifdef UART_TX_BREAK_EN
    input  logic                              break_req,
`endif
    input  logic                              enable,
    input  logic [DIV_WIDTH-1:0]              baud_div,
    input  logic [DATA_BITS-1:0]              data_in,
    input  logic                              data_in_valid,
    output logic                              data_in_ready,
    output logic                              uart_tx,
    output logic                              uart_tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

    tx_state_t            state, state_next;
    logic [DIV_WIDTH-1:0] cnt, cnt_next;
    logic [DIV_WIDTH-1:0] period, period_next;
    logic [DIV_WIDTH-1:0] div_eff;
    logic [3:0]           bits, bits_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 par_bit, par_next;
    logic                 line;
    logic                 pop;
    logic                 push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 bit_end;
`ifdef UART_TX_BREAK_EN
    logic                 brk_pend, brk_pend_next;
`endif

    assign data_in_ready = enable && !rst && !fifo_full;
    assign push          = data_in_valid && data_in_ready;
    assign div_eff       = (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
    assign bit_end       = (cnt == '0);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (!enable),
        .push  (push),
        .wdata (data_in),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state, bit sequencing and line value for the frame FSM.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        period_next = period;
        bits_next   = bits;
        shreg_next  = shreg;
        par_next    = par_bit;
        pop         = 1'b0;
        line        = STOP_BIT;
`ifdef UART_TX_BREAK_EN
        brk_pend_next = brk_pend;
`endif
        case (state)
            IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (break_req) begin
                    line          = START_BIT;
                    brk_pend_next = 1'b1;
                    cnt_next      = div_eff - ONE;
                end else if (brk_pend) begin
                    if (bit_end) brk_pend_next = 1'b0;
                    else         cnt_next      = cnt - ONE;
                end else
`endif
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    shreg_next  = fifo_rdata;
                    par_next    = (PARITY_MODE == PAR_ODD) ? ~(^fifo_rdata) : (^fifo_rdata);
                    period_next = div_eff;
                    cnt_next    = div_eff - ONE;
                    state_next  = START;
                end
            end
            START: begin
                line = START_BIT;
                if (bit_end) begin
                    cnt_next   = period - ONE;
                    bits_next  = 4'(DATA_BITS - 1);
                    state_next = DATA;
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            DATA: begin
                line = (LSB_FIRST != 0) ? shreg[0] : shreg[DATA_BITS-1];
                if (bit_end) begin
                    cnt_next   = period - ONE;
                    shreg_next = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
                    if (bits == 4'd0) begin
                        state_next = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
                        bits_next  = 4'(STOP_BITS - 1);
                    end else begin
                        bits_next = bits - 4'd1;
                    end
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            PARITY: begin
                line = par_bit;
                if (bit_end) begin
                    cnt_next   = period - ONE;
                    bits_next  = 4'(STOP_BITS - 1);
                    state_next = STOP;
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            STOP: begin
                line = STOP_BIT;
                if (bit_end) begin
                    if (bits == 4'd0) begin
                        state_next = IDLE;
                    end else begin
                        bits_next = bits - 4'd1;
                        cnt_next  = period - ONE;
                    end
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; disabling behaves like reset so the frame is truncated at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || !enable) begin
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            bits         <= '0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            uart_tx      <= STOP_BIT;
            uart_tx_busy <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_pend     <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            period       <= period_next;
            bits         <= bits_next;
            shreg        <= shreg_next;
            par_bit      <= par_next;
            uart_tx      <= line;
            uart_tx_busy <= (state != IDLE) || (fifo_count != '0);
`ifdef UART_TX_BREAK_EN
            brk_pend     <= brk_pend_next;
`endif
        end
    end

endmodule
